// File: rtl/z80_stack_engine.sv
// z80_stack_engine
// Multi-cycle PUSH/POP sequencer that owns the architectural stack pointer.
// A command moves a WORD_BYTES-byte word to or from memory, one byte per bus
// handshake. PUSH writes the high byte at SP-1 and walks down; POP reads the
// low byte at SP and walks up. SP only changes on completion or on sp_load.
//
// Optional build macro: Z80_STACK_GUARD_EN
//   Adds sp_limit/fault; a PUSH that would cross sp_limit completes at once
//   with fault=1, no bus traffic and SP unchanged.
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready is combinational)
//   cmd_pop, cmd_wdata     operation select and PUSH word
//   sp_load, sp_load_value SP load, honoured only while idle
//   sp                     architectural SP
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  byte bus
//   rsp_valid, rsp_rdata   completion pulse, last POP result
//   sp_limit, fault        (Z80_STACK_GUARD_EN only) stack guard
module z80_stack_engine #(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter int unsigned            WORD_BYTES = 2,
    parameter logic [ADDR_WIDTH-1:0]  SP_RESET   = '1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_pop,
    input  logic [8*WORD_BYTES-1:0]   cmd_wdata,
    input  logic                      sp_load,
    input  logic [ADDR_WIDTH-1:0]     sp_load_value,
    output logic [ADDR_WIDTH-1:0]     sp,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [7:0]                mem_wdata,
    input  logic [7:0]                mem_rdata,
    input  logic                      mem_ack,
    output logic                      rsp_valid,
`ifdef Z80_STACK_GUARD_EN
    output logic [8*WORD_BYTES-1:0]   rsp_rdata,
    input  logic [ADDR_WIDTH-1:0]     sp_limit,
    output logic                      fault
`else
    output logic [8*WORD_BYTES-1:0]   rsp_rdata
`endif
);

    localparam int unsigned           DATA_W = 8 * WORD_BYTES;
    localparam int unsigned           CNT_W  = 4;
    localparam logic [CNT_W-1:0]      LAST_K = CNT_W'(WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] N_A    = ADDR_WIDTH'(WORD_BYTES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_pop;
    logic [DATA_W-1:0]       r_data;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   r_sp;
    logic [CNT_W-1:0]        r_k;
    logic [DATA_W-1:0]       r_acc;
    logic [DATA_W-1:0]       r_rsp_rdata;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [7:0]              r_mem_wdata;
    logic                    r_rsp_valid;
    logic [DATA_W-1:0]       w_acc_nxt;
    logic                    w_accept;
    logic                    w_ack;
    logic                    w_last;
    logic                    w_guard_c;
    logic                    w_start;

    assign cmd_ready = (r_state == S_IDLE) && !sp_load;
    assign w_accept  = cmd_valid && cmd_ready;
    // mem_req is high for the whole of XFER, so any ack there is a real one
    assign w_ack     = (r_state == S_XFER) && mem_ack;
    assign w_last    = w_ack && (r_k == LAST_K);

`ifdef Z80_STACK_GUARD_EN
    // Widened compare so sp_limit + WORD_BYTES cannot wrap
    localparam int unsigned GW = ADDR_WIDTH + 4;
    logic r_fault;
    assign w_guard_c = !cmd_pop && (GW'(r_sp) < (GW'(sp_limit) + GW'(WORD_BYTES)));
    assign fault     = r_fault;
`else
    assign w_guard_c = 1'b0;
`endif

    assign w_start = w_accept && !w_guard_c;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_XFER;
            S_XFER:  if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // POP accumulator with the current read byte merged into slot k
    always_comb begin
        w_acc_nxt = r_acc;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (r_k == CNT_W'(i)) w_acc_nxt[i*8 +: 8] = mem_rdata;
        end
    end

    // Datapath and registered bus/response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sp        <= SP_RESET;
            r_pop       <= 1'b0;
            r_data      <= '0;
            r_base      <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_rsp_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
`ifdef Z80_STACK_GUARD_EN
            r_fault     <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
`ifdef Z80_STACK_GUARD_EN
            r_fault     <= 1'b0;
`endif
            if ((r_state == S_IDLE) && sp_load) begin
                r_sp <= sp_load_value;
            end

            if (w_accept) begin
                r_pop  <= cmd_pop;
                r_base <= r_sp;
                r_k    <= '0;
                if (w_guard_c) begin
                    r_rsp_valid <= 1'b1;
`ifdef Z80_STACK_GUARD_EN
                    r_fault     <= 1'b1;
`endif
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= !cmd_pop;
                    r_mem_addr  <= cmd_pop ? r_sp : (r_sp - ADDR_WIDTH'(1));
                    r_mem_wdata <= cmd_pop ? 8'h00 : cmd_wdata[DATA_W-1 -: 8];
                    r_data      <= cmd_wdata << 8;
                end
            end

            if (w_ack) begin
                r_acc <= w_acc_nxt;
                if (w_last) begin
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_sp        <= r_pop ? (r_base + N_A) : (r_base - N_A);
                    if (r_pop) r_rsp_rdata <= w_acc_nxt;
                end else begin
                    r_k         <= r_k + CNT_W'(1);
                    r_mem_addr  <= r_pop ? (r_mem_addr + ADDR_WIDTH'(1))
                                         : (r_mem_addr - ADDR_WIDTH'(1));
                    r_mem_wdata <= r_pop ? 8'h00 : r_data[DATA_W-1 -: 8];
                    r_data      <= r_data << 8;
                end
            end
        end
    end

    assign sp        = r_sp;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_z80_stack_engine.sv
// Bench for z80_stack_engine: DUT A (2-byte words, wait-state memory) and
// DUT B (4-byte words, zero-wait memory). Expected bus writes and responses
// are queued when a command is issued and popped by negedge monitors.
module tb_z80_stack_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [15:0] sp;
        logic [31:0] rd;
        logic        fault;
    } rsp_t;

    // ---------------- DUT A: WORD_BYTES = 2 ----------------
    logic        a_valid, a_ready, a_pop, a_load;
    logic [15:0] a_wdata, a_load_val, a_sp, a_addr, a_rrd;
    logic        a_req, a_we, a_ack, a_rsp, a_spur;
    logic [7:0]  a_mwdata, a_mrdata;
`ifdef Z80_STACK_GUARD_EN
    logic [15:0] a_limit;
    logic        a_fault;
`endif

    z80_stack_engine #(.ADDR_WIDTH(16), .WORD_BYTES(2)) u_dut_a (
        .clk           (clk),
        .reset_n       (rst_n),
        .cmd_valid     (a_valid),
        .cmd_ready     (a_ready),
        .cmd_pop       (a_pop),
        .cmd_wdata     (a_wdata),
        .sp_load       (a_load),
        .sp_load_value (a_load_val),
        .sp            (a_sp),
        .mem_req       (a_req),
        .mem_we        (a_we),
        .mem_addr      (a_addr),
        .mem_wdata     (a_mwdata),
        .mem_rdata     (a_mrdata),
        .mem_ack       (a_ack),
        .rsp_valid     (a_rsp),
`ifdef Z80_STACK_GUARD_EN
        .rsp_rdata     (a_rrd),
        .sp_limit      (a_limit),
        .fault         (a_fault)
`else
        .rsp_rdata     (a_rrd)
`endif
    );

    logic [7:0] a_mem [0:65535];
    logic [7:0] a_sh  [0:65535];
    int         a_wait_cfg = 0;
    int         a_wcnt = 0;

    assign a_ack    = (a_req && (a_wcnt >= a_wait_cfg)) || a_spur;
    assign a_mrdata = a_mem[a_addr];

    always @(posedge clk) begin
        if (a_req && !a_ack) a_wcnt <= a_wcnt + 1;
        else                 a_wcnt <= 0;
        if (a_req && a_ack && a_we) a_mem[a_addr] <= a_mwdata;
    end

    wr_t         a_wq[$];
    rsp_t        a_rq[$];
    logic [15:0] a_spm;
    logic [15:0] a_last;
    int          a_rsp_cnt = 0;
    int          a_rsp_cyc = 0;
    int          a_acc_cyc = 0;
    logic        a_hold = 1'b0;
    logic [15:0] a_hold_addr = 16'h0;

    // Monitor A: bus writes, wait-state stability, responses
    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        if (!rst_n) begin
            a_hold = 1'b0;
        end else begin
            if (a_req && a_ack && a_we) begin
                if (a_wq.size() == 0) check_eq("a_unexp_wr", 32'(a_addr), 32'hFFFF_FFFF);
                else begin
                    w = a_wq.pop_front();
                    check_eq("a_wr_addr", 32'(a_addr), 32'(w.addr));
                    check_eq("a_wr_data", 32'(a_mwdata), 32'(w.data));
                end
            end
            if (a_hold) begin
                check_eq("a_hold_req",  32'(a_req),  32'd1);
                check_eq("a_hold_addr", 32'(a_addr), 32'(a_hold_addr));
            end
            a_hold      = a_req && !a_ack;
            a_hold_addr = a_addr;
            if (a_rsp) begin
                a_rsp_cnt++;
                a_rsp_cyc = cyc;
                if (a_rq.size() == 0) check_eq("a_unexp_rsp", 32'd1, 32'd0);
                else begin
                    r = a_rq.pop_front();
                    check_eq("a_rsp_sp", 32'(a_sp), 32'(r.sp));
                    check_eq("a_rsp_rdata", 32'(a_rrd), r.rd);
`ifdef Z80_STACK_GUARD_EN
                    check_eq("a_rsp_fault", 32'(a_fault), 32'(r.fault));
`endif
                    if (!a_load) check_eq("a_rdy_at_rsp", 32'(a_ready), 32'd1);
                end
            end
        end
    end

    // Queue expected writes/response for one A command from the bench's SP model
    task automatic a_expect(input logic pop, input logic [15:0] wd);
        rsp_t        r;
        wr_t         w;
        logic [15:0] ad;
        logic        f;
        f = 1'b0;
`ifdef Z80_STACK_GUARD_EN
        f = !pop && ({1'b0, a_spm} < ({1'b0, a_limit} + 17'd2));
`endif
        if (f) begin
            r.sp = a_spm;
        end else if (!pop) begin
            for (int k = 0; k < 2; k++) begin
                ad     = a_spm - 16'(k + 1);
                w.addr = ad;
                w.data = (k == 0) ? wd[15:8] : wd[7:0];
                a_wq.push_back(w);
                a_sh[ad] = w.data;
            end
            a_spm = a_spm - 16'd2;
            r.sp  = a_spm;
        end else begin
            ad     = a_spm + 16'd1;
            a_last = {a_sh[ad], a_sh[a_spm]};
            a_spm  = a_spm + 16'd2;
            r.sp   = a_spm;
        end
        r.rd    = {16'h0, a_last};
        r.fault = f;
        a_rq.push_back(r);
    endtask

    task automatic a_cmd(input logic pop, input logic [15:0] wd);
        int   target;
        logic ok;
        target = a_rsp_cnt + 1;
        a_expect(pop, wd);
        a_pop   = pop;
        a_wdata = wd;
        a_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (a_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check_eq("a_accept_timeout", 32'd0, 32'd1);
            a_valid = 1'b0;
            a_wq.delete();
            a_rq.delete();
            return;
        end
        @(posedge clk);
        @(negedge clk);
        a_acc_cyc = cyc;
        a_valid   = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_rsp_cnt >= target) begin ok = 1'b1; break; end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            check_eq("a_rsp_timeout", 32'd0, 32'd1);
            a_wq.delete();
            a_rq.delete();
        end
    endtask

    task automatic a_load_sp(input logic [15:0] v);
        @(negedge clk);
        a_load     = 1'b1;
        a_load_val = v;
        @(negedge clk);
        a_load = 1'b0;
        a_spm  = v;
    endtask

    // ---------------- DUT B: WORD_BYTES = 4 ----------------
    logic        b_valid, b_ready, b_pop, b_load;
    logic [31:0] b_wdata, b_rrd;
    logic [15:0] b_load_val, b_sp, b_addr;
    logic        b_req, b_we, b_rsp;
    logic [7:0]  b_mwdata, b_mrdata;
`ifdef Z80_STACK_GUARD_EN
    logic [15:0] b_limit;
    logic        b_fault;
`endif

    z80_stack_engine #(.ADDR_WIDTH(16), .WORD_BYTES(4)) u_dut_b (
        .clk           (clk),
        .reset_n       (rst_n),
        .cmd_valid     (b_valid),
        .cmd_ready     (b_ready),
        .cmd_pop       (b_pop),
        .cmd_wdata     (b_wdata),
        .sp_load       (b_load),
        .sp_load_value (b_load_val),
        .sp            (b_sp),
        .mem_req       (b_req),
        .mem_we        (b_we),
        .mem_addr      (b_addr),
        .mem_wdata     (b_mwdata),
        .mem_rdata     (b_mrdata),
        .mem_ack       (b_req),
        .rsp_valid     (b_rsp),
`ifdef Z80_STACK_GUARD_EN
        .rsp_rdata     (b_rrd),
        .sp_limit      (b_limit),
        .fault         (b_fault)
`else
        .rsp_rdata     (b_rrd)
`endif
    );

    logic [7:0] b_mem [0:65535];
    assign b_mrdata = b_mem[b_addr];
    always @(posedge clk) if (b_req && b_we) b_mem[b_addr] <= b_mwdata;

    wr_t         b_wq[$];
    rsp_t        b_rq[$];
    int          b_rsp_cnt = 0;
    int          b_rsp_cyc = 0;
    int          b_acc_cyc = 0;

    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        if (rst_n) begin
            if (b_req && b_we) begin
                if (b_wq.size() == 0) check_eq("b_unexp_wr", 32'(b_addr), 32'hFFFF_FFFF);
                else begin
                    w = b_wq.pop_front();
                    check_eq("b_wr_addr", 32'(b_addr), 32'(w.addr));
                    check_eq("b_wr_data", 32'(b_mwdata), 32'(w.data));
                end
            end
            if (b_rsp) begin
                b_rsp_cnt++;
                b_rsp_cyc = cyc;
                if (b_rq.size() == 0) check_eq("b_unexp_rsp", 32'd1, 32'd0);
                else begin
                    r = b_rq.pop_front();
                    check_eq("b_rsp_sp", 32'(b_sp), 32'(r.sp));
                    check_eq("b_rsp_rdata", b_rrd, r.rd);
                end
            end
        end
    end

    // Runs one B command; expectations are supplied by the caller
    task automatic b_cmd(input logic pop, input logic [31:0] wd);
        int   target;
        logic ok;
        target  = b_rsp_cnt + 1;
        b_pop   = pop;
        b_wdata = wd;
        b_valid = 1'b1;
        #1;
        if (!b_ready) check_eq("b_ready_idle", 32'(b_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        b_acc_cyc = cyc;
        b_valid   = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b_rsp_cnt >= target) begin ok = 1'b1; break; end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            check_eq("b_rsp_timeout", 32'd0, 32'd1);
            b_wq.delete();
            b_rq.delete();
        end
    endtask

    // ---------------- Stimulus ----------------
    logic [15:0] vals [4];

    initial begin
        wr_t  w;
        rsp_t r;
        logic [15:0] bad;
        rst_n = 1'b0;
        a_valid = 1'b0; a_pop = 1'b0; a_wdata = 16'h0; a_load = 1'b0; a_load_val = 16'h0; a_spur = 1'b0;
        b_valid = 1'b0; b_pop = 1'b0; b_wdata = 32'h0; b_load = 1'b0; b_load_val = 16'h0;
`ifdef Z80_STACK_GUARD_EN
        a_limit = 16'h0000;
        b_limit = 16'h0000;
`endif
        a_spm  = 16'hFFFF;
        a_last = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Reset state
        check_eq("rst_sp",    32'(a_sp),    32'hFFFF);
        check_eq("rst_req",   32'(a_req),   32'd0);
        check_eq("rst_we",    32'(a_we),    32'd0);
        check_eq("rst_rsp",   32'(a_rsp),   32'd0);
        check_eq("rst_rdata", 32'(a_rrd),   32'd0);
        check_eq("rst_addr",  32'(a_addr),  32'd0);
        check_eq("rst_ready", 32'(a_ready), 32'd1);
        check_eq("rst_b_sp",  32'(b_sp),    32'hFFFF);

        // PUSH 0x1234 at SP=0x8000, zero-wait
        a_load_sp(16'h8000);
        #1;
        check_eq("load_sp", 32'(a_sp), 32'h8000);
        a_wait_cfg = 0;
        a_cmd(1'b0, 16'h1234);
        check_eq("push_latency", 32'(a_rsp_cyc - a_acc_cyc), 32'd2);
        check_eq("push_sp", 32'(a_sp), 32'h7FFE);

        // POP with two wait cycles per byte
        a_wait_cfg = 2;
        a_cmd(1'b1, 16'h0);
        check_eq("pop_rdata", 32'(a_rrd), 32'h1234);
        check_eq("pop_sp",    32'(a_sp),  32'h8000);

        // Random pushes then pops, LIFO order
        for (int i = 0; i < 4; i++) begin
            vals[i]    = 16'($urandom);
            a_wait_cfg = $urandom_range(0, 2);
            a_cmd(1'b0, vals[i]);
        end
        for (int i = 0; i < 4; i++) begin
            a_wait_cfg = $urandom_range(0, 2);
            a_cmd(1'b1, 16'h0);
            check_eq("lifo", 32'(a_rrd), 32'(vals[3-i]));
        end
        check_eq("lifo_sp", 32'(a_sp), 32'h8000);

        // Ack without a request is ignored
        @(negedge clk);
        a_spur = 1'b1;
        repeat (3) @(negedge clk);
        a_spur = 1'b0;
        #1;
        check_eq("spur_sp",  32'(a_sp),  32'h8000);
        check_eq("spur_req", 32'(a_req), 32'd0);

        // sp_load has priority over cmd_valid
        @(negedge clk);
        a_load     = 1'b1;
        a_load_val = 16'h0001;
        a_valid    = 1'b1;
        a_pop      = 1'b0;
        a_wdata    = 16'h5555;
        #1;
        check_eq("load_blocks_ready", 32'(a_ready), 32'd0);
        @(negedge clk);
        a_load  = 1'b0;
        a_valid = 1'b0;
        a_spm   = 16'h0001;
        #1;
        check_eq("load_sp_1",     32'(a_sp),  32'h0001);
        check_eq("load_no_xfer",  32'(a_req), 32'd0);

        // PUSH across address zero
        a_wait_cfg = 1;
        a_cmd(1'b0, 16'hABCD);
`ifndef Z80_STACK_GUARD_EN
        check_eq("wrap_sp", 32'(a_sp), 32'hFFFF);
`endif

`ifdef Z80_STACK_GUARD_EN
        // Guarded PUSH: no bus traffic, fault pulse, SP unchanged
        a_limit = 16'h7000;
        a_load_sp(16'h7001);
        a_cmd(1'b0, 16'h9999);
        check_eq("guard_sp",    32'(a_sp),    32'h7001);
        check_eq("guard_fault_clr", 32'(a_fault), 32'd0);
        a_limit = 16'h0000;
`endif

        // Reset during byte 1 of a PUSH
        a_load_sp(16'h4000);
        a_wait_cfg = 0;
        a_expect(1'b0, 16'h7777);
        a_pop   = 1'b0;
        a_wdata = 16'h7777;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        check_eq("b1_req_before_rst", 32'(a_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req", 32'(a_req), 32'd0);
        check_eq("rst_mid_sp",  32'(a_sp),  32'hFFFF);
        check_eq("rst_mid_rsp", 32'(a_rsp), 32'd0);
        a_wq.delete();
        a_rq.delete();
        a_spm  = 16'hFFFF;
        a_last = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("post_rst_sp",    32'(a_sp),  32'hFFFF);
        check_eq("post_rst_rdata", 32'(a_rrd), 32'd0);
        check_eq("post_rst_req",   32'(a_req), 32'd0);

        // DUT B: 4-byte PUSH 0xDEADBEEF at 0x1000, then POP it back
        @(negedge clk);
        b_load     = 1'b1;
        b_load_val = 16'h1000;
        @(negedge clk);
        b_load = 1'b0;
        bad    = 16'h0FFF;
        for (int k = 0; k < 4; k++) begin
            w.addr = bad - 16'(k);
            w.data = (k == 0) ? 8'hDE : (k == 1) ? 8'hAD : (k == 2) ? 8'hBE : 8'hEF;
            b_wq.push_back(w);
        end
        r.sp = 16'h0FFC; r.rd = 32'h0; r.fault = 1'b0;
        b_rq.push_back(r);
        b_cmd(1'b0, 32'hDEADBEEF);
        check_eq("b_push_latency", 32'(b_rsp_cyc - b_acc_cyc), 32'd4);
        check_eq("b_push_sp", 32'(b_sp), 32'h0FFC);
        r.sp = 16'h1000; r.rd = 32'hDEADBEEF; r.fault = 1'b0;
        b_rq.push_back(r);
        b_cmd(1'b1, 32'h0);
        check_eq("b_pop_rdata", b_rrd, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        check_eq("a_wq_drained", 32'(a_wq.size()), 32'd0);
        check_eq("a_rq_drained", 32'(a_rq.size()), 32'd0);
        check_eq("b_wq_drained", 32'(b_wq.size()), 32'd0);
        check_eq("b_rq_drained", 32'(b_rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
